// File: rtl/tdm_demux.sv
// Receive side of the 4-channel TDM byte link: aligns to sof and rebuilds the
// four channel words, publishing them together once per complete frame.
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [1:0]       slot,
    output logic             busy,
    output logic             frame_valid,
    output logic             frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_slot;
    logic [1:0]       w_slot_nxt;
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_s0_nxt;
    logic [WIDTH-1:0] w_s1_nxt;
    logic [WIDTH-1:0] w_s2_nxt;
    logic             w_load;
    logic             w_fv_nxt;
    logic             w_fe_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_s0_nxt    = r_s0;
        w_s1_nxt    = r_s1;
        w_s2_nxt    = r_s2;
        w_load      = 1'b0;
        w_fv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;

        if (din_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (sof) begin
                        w_s0_nxt    = din;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (sof) begin
                        // Mid-frame sof: drop the partial frame and resync on this beat.
                        w_fe_nxt   = 1'b1;
                        w_s0_nxt   = din;
                        w_slot_nxt = 2'd1;
                    end else begin
                        unique case (r_slot)
                            2'd1: begin
                                w_s1_nxt   = din;
                                w_slot_nxt = 2'd2;
                            end
                            2'd2: begin
                                w_s2_nxt   = din;
                                w_slot_nxt = 2'd3;
                            end
                            2'd3: begin
                                w_load      = 1'b1;
                                w_fv_nxt    = 1'b1;
                                w_slot_nxt  = 2'd0;
                                w_state_nxt = IDLE;
                            end
                            default: begin
                                w_slot_nxt  = 2'd0;
                                w_state_nxt = IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_s0        <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            D0          <= '0;
            D1          <= '0;
            D2          <= '0;
            D3          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot      <= w_slot_nxt;
            r_s0        <= w_s0_nxt;
            r_s1        <= w_s1_nxt;
            r_s2        <= w_s2_nxt;
            frame_valid <= w_fv_nxt;
            frame_err   <= w_fe_nxt;
            if (w_load) begin
                D0 <= r_s0;
                D1 <= r_s1;
                D2 <= r_s2;
                D3 <= din;
            end
        end
    end

    assign slot = r_slot;
    assign busy = (r_state == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: hand-computed frames, gaps, resync and reset.
module tb_tdm_demux;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       sof;
    logic [7:0] D0, D1, D2, D3;
    logic [1:0] slot;
    logic       busy;
    logic       frame_valid;
    logic       frame_err;

    int unsigned n_checks;
    int unsigned n_fail;

    tdm_demux #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .sof(sof),
        .D0(D0),
        .D1(D1),
        .D2(D2),
        .D3(D3),
        .slot(slot),
        .busy(busy),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge sample them, then settle 1 time unit.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, 8'hEE);
    endtask

    task automatic chk_d(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        chk({tag, ".D0"}, {24'd0, D0}, {24'd0, a});
        chk({tag, ".D1"}, {24'd0, D1}, {24'd0, b});
        chk({tag, ".D2"}, {24'd0, D2}, {24'd0, c});
        chk({tag, ".D3"}, {24'd0, D3}, {24'd0, d});
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] e_slot, input logic e_busy,
                           input logic e_fv, input logic e_fe);
        chk({tag, ".slot"}, {30'd0, slot}, {30'd0, e_slot});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".fv"}, {31'd0, frame_valid}, {31'd0, e_fv});
        chk({tag, ".fe"}, {31'd0, frame_err}, {31'd0, e_fe});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        sof       = 1'b0;

        // 1: reset state, then a clean frame
        do_reset();
        chk_d("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_ctl("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h01);
        chk_ctl("t1.b0", 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h03);
        chk_ctl("t1.b1", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h07);
        chk_ctl("t1.b2", 2'd3, 1'b1, 1'b0, 1'b0);
        chk_d("t1.b2", 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h0F);
        chk_d("t1.done", 8'h01, 8'h03, 8'h07, 8'h0F);
        chk_ctl("t1.done", 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk_ctl("t1.after", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_d("t1.after", 8'h01, 8'h03, 8'h07, 8'h0F);

        // 2: same frame with invalid gaps (sof held high while invalid)
        do_reset();
        step(1'b1, 1'b1, 8'h01);
        gap(1);
        chk_ctl("t2.g1", 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h03);
        gap(3);
        chk_ctl("t2.g3", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h07);
        gap(2);
        chk_ctl("t2.g2", 2'd3, 1'b1, 1'b0, 1'b0);
        chk_d("t2.g2", 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h0F);
        chk_d("t2.done", 8'h01, 8'h03, 8'h07, 8'h0F);
        chk_ctl("t2.done", 2'd0, 1'b0, 1'b1, 1'b0);

        // 3: non-sof beats in IDLE are discarded silently
        do_reset();
        step(1'b1, 1'b0, 8'hAA);
        chk_ctl("t3.aa", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hBB);
        chk_ctl("t3.bb", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 8'h07);
        step(1'b1, 1'b0, 8'h0F);
        chk_d("t3.done", 8'h01, 8'h03, 8'h07, 8'h0F);
        chk_ctl("t3.done", 2'd0, 1'b0, 1'b1, 1'b0);

        // 4: sof mid-frame -> error pulse and resync
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        chk_ctl("t4.22", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33);
        chk_ctl("t4.err", 2'd1, 1'b1, 1'b0, 1'b1);
        chk_d("t4.err", 8'h01, 8'h03, 8'h07, 8'h0F);
        step(1'b1, 1'b0, 8'h44);
        chk_ctl("t4.44", 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h55);
        chk_d("t4.55", 8'h01, 8'h03, 8'h07, 8'h0F);
        step(1'b1, 1'b0, 8'h66);
        chk_d("t4.done", 8'h33, 8'h44, 8'h55, 8'h66);
        chk_ctl("t4.done", 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk_ctl("t4.after", 2'd0, 1'b0, 1'b0, 1'b0);

        // 5: back-to-back frames
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 8'h07);
        step(1'b1, 1'b0, 8'h0F);
        chk_d("t5.f1", 8'h01, 8'h03, 8'h07, 8'h0F);
        chk_ctl("t5.f1", 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hF0);
        chk_ctl("t5.f2b0", 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hE0);
        step(1'b1, 1'b0, 8'hC0);
        chk_ctl("t5.f2b2", 2'd3, 1'b1, 1'b0, 1'b0);
        chk_d("t5.f2b2", 8'h01, 8'h03, 8'h07, 8'h0F);
        step(1'b1, 1'b0, 8'h80);
        chk_d("t5.f2", 8'hF0, 8'hE0, 8'hC0, 8'h80);
        chk_ctl("t5.f2", 2'd0, 1'b0, 1'b1, 1'b0);

        // 6: reset mid-frame (inputs active during reset), then a full frame
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'hA3);
        chk_d("t6.rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_ctl("t6.rst", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA4);
        chk_ctl("t6.rst2", 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'hA5);
        chk_ctl("t6.idle", 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h12);
        step(1'b1, 1'b0, 8'h34);
        step(1'b1, 1'b0, 8'h56);
        step(1'b1, 1'b0, 8'h78);
        chk_d("t6.done", 8'h12, 8'h34, 8'h56, 8'h78);
        chk_ctl("t6.done", 2'd0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
